// File: rtl/vga_timing_monitor.sv
// Receive-side VGA raster checker: measures line/frame timing against nominal values and tracks lock.
// Optional active-width checking is compiled in with VMON_ACTIVE_CHECK_EN.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2,
  parameter int HW          = 10,
  parameter int VW          = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          pix_en,
  input  logic          hSync,
  input  logic          vSync,
  input  logic          bright,
  output logic          locked,
  output logic [HW-1:0] h_period,
  output logic [VW-1:0] v_period,
  output logic [3:0]    err_flags,
  output logic [7:0]    err_count,
  output logic          frame_pulse
);

  // The line counter must be able to reach the 2-line timeout, which can exceed HW bits.
  localparam int HCW = $clog2(2*H_TOTAL+1);
  localparam int GW  = $clog2(LOCK_FRAMES+1);

  localparam logic [HCW-1:0] H_TOT_C   = HCW'(H_TOTAL);
  localparam logic [HCW-1:0] TMO_M1    = HCW'(2*H_TOTAL-1);
  localparam logic [HCW-1:0] HC_ONE    = HCW'(1);
  localparam logic [HW-1:0]  H_SYNC_C  = HW'(H_SYNC);
  localparam logic [HW-1:0]  HW_ONE    = HW'(1);
  localparam logic [VW-1:0]  V_TOT_C   = VW'(V_TOTAL);
  localparam logic [VW-1:0]  VW_ONE    = VW'(1);
  localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_FRAMES-1);
  localparam logic [GW-1:0]  G_ONE     = GW'(1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             prev_h_q, prev_h_d, prev_v_q, prev_v_d;
  logic [HCW-1:0]   h_cnt_q, h_cnt_d;
  logic [HW-1:0]    hs_cnt_q, hs_cnt_d;
  logic [VW-1:0]    v_cnt_q, v_cnt_d;
  logic             h_ref_q, h_ref_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic             line_acc_q, line_acc_d;
  logic             locked_q, locked_d;
  logic [HW-1:0]    h_period_q, h_period_d;
  logic [VW-1:0]    v_period_q, v_period_d;
  logic [3:0]       err_flags_q, err_flags_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             frame_pulse_q, frame_pulse_d;
  logic             h_edge, h_rise, v_edge, chk, lerr, verr, timeout;

`ifdef VMON_ACTIVE_CHECK_EN
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  logic [HW-1:0] act_cnt_q, act_cnt_d;
`else
  localparam int unused_h_active = H_ACTIVE;
  logic unused_bright;
  assign unused_bright = bright;
`endif

  function automatic logic [HCW-1:0] sat_hc(input logic [HCW-1:0] x);
    return (x == '1) ? x : x + HC_ONE;
  endfunction

  function automatic logic [HW-1:0] sat_h(input logic [HW-1:0] x);
    return (x == '1) ? x : x + HW_ONE;
  endfunction

  function automatic logic [VW-1:0] sat_v(input logic [VW-1:0] x);
    return (x == '1) ? x : x + VW_ONE;
  endfunction

  always_comb begin
    state_d       = state_q;
    prev_h_d      = prev_h_q;
    prev_v_d      = prev_v_q;
    h_cnt_d       = h_cnt_q;
    hs_cnt_d      = hs_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_ref_d       = h_ref_q;
    good_cnt_d    = good_cnt_q;
    line_acc_d    = line_acc_q;
    locked_d      = locked_q;
    h_period_d    = h_period_q;
    v_period_d    = v_period_q;
    err_flags_d   = err_flags_q;
    err_count_d   = err_count_q;
    frame_pulse_d = 1'b0;
    h_edge        = 1'b0;
    h_rise        = 1'b0;
    v_edge        = 1'b0;
    chk           = 1'b0;
    lerr          = 1'b0;
    verr          = 1'b0;
    timeout       = 1'b0;
`ifdef VMON_ACTIVE_CHECK_EN
    act_cnt_d     = act_cnt_q;
`endif
    if (pix_en) begin
      h_edge        = prev_h_q & ~hSync;
      h_rise        = ~prev_h_q & hSync;
      v_edge        = prev_v_q & ~vSync;
      prev_h_d      = hSync;
      prev_v_d      = vSync;
      frame_pulse_d = v_edge;
      chk           = (state_q != SEARCH) && h_ref_q;

      if (h_edge) begin
        h_period_d = HW'(h_cnt_q + HC_ONE);
        h_cnt_d    = '0;
        hs_cnt_d   = HW_ONE;
        v_cnt_d    = sat_v(v_cnt_q);
        if (state_q != SEARCH) h_ref_d = 1'b1;
        if (chk && ((h_cnt_q + HC_ONE) != H_TOT_C)) begin
          lerr           = 1'b1;
          err_flags_d[0] = 1'b1;
        end
      end else begin
        h_cnt_d = sat_hc(h_cnt_q);
        if (!hSync) hs_cnt_d = sat_h(hs_cnt_q);
        timeout = (h_cnt_q == TMO_M1);
      end

      if (h_rise) begin
        if (chk && (hs_cnt_q != H_SYNC_C)) begin
          lerr           = 1'b1;
          err_flags_d[1] = 1'b1;
        end
        hs_cnt_d = '0;
      end

`ifdef VMON_ACTIVE_CHECK_EN
      // Lines with no bright pixels (blanking lines) are not active-width checked.
      if (h_edge) begin
        if (chk && (act_cnt_q != '0) && (act_cnt_q != H_ACT_C)) begin
          lerr           = 1'b1;
          err_flags_d[3] = 1'b1;
        end
        act_cnt_d = bright ? HW_ONE : '0;
      end else if (bright) begin
        act_cnt_d = sat_h(act_cnt_q);
      end
`endif

      if (lerr) begin
        line_acc_d = 1'b1;
        if (state_q == LOCKED) begin
          state_d    = TRACK;
          locked_d   = 1'b0;
          good_cnt_d = '0;
        end
      end

      // A line error on the vSync sample closes the previous frame's last line, so it counts here.
      if (v_edge) begin
        v_period_d = v_cnt_q;
        v_cnt_d    = h_edge ? VW_ONE : '0;
        line_acc_d = 1'b0;
        if (state_q == SEARCH) begin
          state_d    = TRACK;
          h_ref_d    = 1'b0;
          good_cnt_d = '0;
        end else begin
          verr = (v_cnt_q != V_TOT_C);
          if (verr) err_flags_d[2] = 1'b1;
          if (verr || line_acc_q || lerr) begin
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
            good_cnt_d  = '0;
            state_d     = TRACK;
            locked_d    = 1'b0;
          end else if (state_q == TRACK) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              good_cnt_d = GW'(LOCK_FRAMES);
            end else begin
              good_cnt_d = good_cnt_q + G_ONE;
            end
          end
        end
      end

      if (timeout) begin
        state_d        = SEARCH;
        locked_d       = 1'b0;
        err_flags_d[0] = 1'b1;
        h_ref_d        = 1'b0;
        good_cnt_d     = '0;
        line_acc_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= SEARCH;
      prev_h_q      <= 1'b1;
      prev_v_q      <= 1'b1;
      h_cnt_q       <= '0;
      hs_cnt_q      <= '0;
      v_cnt_q       <= '0;
      h_ref_q       <= 1'b0;
      good_cnt_q    <= '0;
      line_acc_q    <= 1'b0;
      locked_q      <= 1'b0;
      h_period_q    <= '0;
      v_period_q    <= '0;
      err_flags_q   <= '0;
      err_count_q   <= '0;
      frame_pulse_q <= 1'b0;
`ifdef VMON_ACTIVE_CHECK_EN
      act_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      prev_h_q      <= prev_h_d;
      prev_v_q      <= prev_v_d;
      h_cnt_q       <= h_cnt_d;
      hs_cnt_q      <= hs_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_ref_q       <= h_ref_d;
      good_cnt_q    <= good_cnt_d;
      line_acc_q    <= line_acc_d;
      locked_q      <= locked_d;
      h_period_q    <= h_period_d;
      v_period_q    <= v_period_d;
      err_flags_q   <= err_flags_d;
      err_count_q   <= err_count_d;
      frame_pulse_q <= frame_pulse_d;
`ifdef VMON_ACTIVE_CHECK_EN
      act_cnt_q     <= act_cnt_d;
`endif
    end
  end

  assign locked      = locked_q;
  assign h_period    = h_period_q;
  assign v_period    = v_period_q;
  assign err_flags   = err_flags_q;
  assign err_count   = err_count_q;
  assign frame_pulse = frame_pulse_q;

endmodule
